instr_assembler: RTL and testbench
==================================

Name: instr_assembler

Overview:
- Parametrised instruction fetch register: assembles one instruction of BEATS × BUS_W bits from successive data-bus beats, MSB beat first.
- Presents the completed instruction as an opcode/operand pair through a valid/ready output stage.
- Sits between the memory data bus and the controller/decoder.
- Supports any bus width and beat count, backpressure, overlapped fetch of the next instruction, flush, and an optional gap-abort mode.

Parameters:
- BUS_W, 8, data bus width in bits (≥1).
- BEATS, 2, bus beats per instruction (≥2); INSTR_W = BUS_W*BEATS.
- OP_W, 3, opcode width, taken from the top of the instruction (1 ≤ OP_W < INSTR_W).
- ABORT_ON_GAP, 1, 1 = a cycle with no accepted beat while a fetch is partial discards the partial instruction; 0 = partial fetch is held indefinitely.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous discard of partial and completed instruction.
- in_valid  input  1  beat present on in_data.
- in_data  input  BUS_W  data bus beat.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- out_valid  output  1  completed instruction available.
- out_ready  input  1  consumer takes the instruction when out_valid && out_ready.
- opcode  output  OP_W  instr[INSTR_W-1 -: OP_W].
- operand  output  INSTR_W-OP_W  instr[INSTR_W-OP_W-1:0].
- beat_idx  output  clog2(BEATS)  index of the next beat expected.
- partial  output  1  1 when beat_idx != 0.

Behaviour:
- Reset (async): beat_idx=0, partial=0, out_valid=0, opcode=0, operand=0, assembly buffer=0. in_ready is combinational and reads 1 after reset.
- Storage:
  - Assembly buffer holds BEATS-1 beats.
  - Output register holds one full instruction.
  - Beat k (k=0 first) occupies bits [INSTR_W-1-k*BUS_W -: BUS_W].
- Accept, non-final beat (beat_idx < BEATS-1): write the beat into the buffer slot, beat_idx += 1.
- Accept, final beat (beat_idx == BEATS-1):
  - Load the output register with {buffer, in_data}; set out_valid=1; beat_idx wraps to 0 in the same edge.
  - Latency: opcode/operand valid the cycle after the final beat handshake.
- in_ready = !flush && ((beat_idx != BEATS-1) || !out_valid || out_ready).
  - Non-final beats are always accepted, so the next fetch overlaps a stalled output.
  - Only the final beat waits for output space.
  - out_ready→in_ready is a combinational path by design.
- Output handshake:
  - out_valid && out_ready with no final beat accepted: out_valid→0.
  - Simultaneous consume and final-beat accept: out_valid stays 1 and the register takes the new instruction (back-to-back, no bubble).
  - opcode/operand stay stable while out_valid && !out_ready.
  - After consume they retain their last value; they are not cleared.
- Gap abort (ABORT_ON_GAP=1): if partial && !(in_valid && in_ready), then beat_idx→0 next edge and buffered beats are discarded; the output register is unaffected.
  - A final beat stalled by backpressure (in_valid=1, in_ready=0) is also a gap and aborts.
  - With ABORT_ON_GAP=0, partial state is held across idle cycles.
- flush: highest priority. Next edge beat_idx=0 and out_valid=0; in_ready=0 during the flush cycle. Any beat or consume in that cycle has no effect.
- Reset mid-fetch or mid-hold: all state returns to reset values immediately; no partial output is ever produced.
- There is no error state. X on in_data while in_valid=0 is ignored.

Decomposition:
- Shared package cpu_pkg: OP_W, the default BUS_W/BEATS, opcode enumeration constants (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP), and a helper function for the beat_idx width.
- One natural sub-module: instr_out_stage (single-entry valid/ready register with the load/consume rules above), reusable for the data-operand path.
- Beat counter and assembly buffer stay in the top level.

Test Plan:
- Defaults: beats 0xA5 then 0x3C, out_ready=1 → next cycle out_valid=1, opcode=3'b101, operand=13'h053C, beat_idx=0.
- out_ready=0 while holding 0xA53C; send 0x12 → accepted (partial=1). Send 0x34 → in_ready=0 and held. Raise out_ready → 0xA53C consumed and 0x34 accepted the same edge; next cycle opcode=0, operand=13'h1234, out_valid=1.
- ABORT_ON_GAP=1: beat 0xFF, one idle cycle, then 0x11, 0x22 → output 16'h1122 (opcode 0, operand 13'h1122). ABORT_ON_GAP=0, same stimulus → output 16'hFF11, and 0x22 starts a new fetch with partial=1.
- BUS_W=8, BEATS=4, OP_W=6: beats 0xDE, 0xAD, 0xBE, 0xEF → opcode=6'h37, operand=26'h2ADBEEF, beat_idx counts 0,1,2,3,0.
- flush asserted after the first beat while out_valid=1 → next cycle out_valid=0, beat_idx=0, in_ready=0 during the flush cycle; the following two beats yield a clean instruction.
- Assert rst_n low mid-fetch, asynchronously between edges → all outputs are reset values before the next edge; in_ready=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch geometry, opcode encodings and
// a sizing helper for beat counters.
package cpu_pkg;

    localparam int OP_W      = 3;
    localparam int BUS_W_DEF = 8;
    localparam int BEATS_DEF = 2;

    typedef enum logic [OP_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    // A counter over `beats` positions never narrower than one bit.
    function automatic int beat_idx_w(input int beats);
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/instr_out_stage.sv
// Single-entry valid/ready holding register. A load and a consume in the
// same cycle replace the held word without a bubble.
module instr_out_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         consume,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         space
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // Room for a new word now, or at the same edge the held word leaves.
    assign space = !valid_reg || consume;
    assign valid = valid_reg;
    assign data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (consume) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// Instruction fetch register: gathers BEATS bus beats (MSB beat first) into
// one instruction and presents it as opcode/operand through a valid/ready stage.
module instr_assembler #(
    parameter int BUS_W        = cpu_pkg::BUS_W_DEF,
    parameter int BEATS        = cpu_pkg::BEATS_DEF,
    parameter int OP_W         = cpu_pkg::OP_W,
    parameter int ABORT_ON_GAP = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     in_valid,
    input  logic [BUS_W-1:0]                         in_data,
    output logic                                     in_ready,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OP_W-1:0]                          opcode,
    output logic [BUS_W*BEATS-OP_W-1:0]              operand,
    output logic [cpu_pkg::beat_idx_w(BEATS)-1:0]    beat_idx,
    output logic                                     partial
);
    import cpu_pkg::*;

    localparam int INSTR_W = BUS_W * BEATS;
    localparam int IDX_W   = beat_idx_w(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [IDX_W-1:0]   beat_idx_reg;
    wire  [INSTR_W-BUS_W-1:0] buf_flat;
    logic [INSTR_W-1:0] instr;
    logic               is_last;
    logic               accept;
    logic               out_space;

    assign is_last  = (beat_idx_reg == LAST_IDX);
    // Only the final beat needs output room; earlier beats overlap a stalled output.
    assign in_ready = !flush && (!is_last || out_space);
    assign accept   = in_valid && in_ready;
    assign instr    = {buf_flat, in_data};
    assign beat_idx = beat_idx_reg;
    assign partial  = (beat_idx_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < BEATS - 1; gi++) begin : g_slot
            logic [BUS_W-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (accept && beat_idx_reg == IDX_W'(gi)) begin
                    slot_reg <= in_data;
                end
            end

            assign buf_flat[INSTR_W-BUS_W-1-gi*BUS_W -: BUS_W] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx_reg <= '0;
        end else if (flush) begin
            beat_idx_reg <= '0;
        end else if (accept) begin
            beat_idx_reg <= is_last ? '0 : beat_idx_reg + 1'b1;
        end else if (ABORT_ON_GAP != 0 && partial) begin
            // A missed beat mid-fetch discards the partial instruction.
            beat_idx_reg <= '0;
        end
    end

    logic [INSTR_W-1:0] out_data;

    instr_out_stage #(
        .W(INSTR_W)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (accept && is_last),
        .load_data (instr),
        .consume   (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .space     (out_space)
    );

    assign opcode  = out_data[INSTR_W-1 -: OP_W];
    assign operand = out_data[INSTR_W-OP_W-1:0];

endmodule

// File: tb/tb_instr_assembler.sv
// Drives three assembler configurations with shared stimulus and compares each
// against a beat-list reference model of the fetch/hold behaviour.
module tb_instr_assembler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    always #5 clk = ~clk;

    // d0: 8x2 abort on gap, d1: 8x2 hold on gap, d2: 8x4 OP_W=6 hold on gap
    logic        ir0, ov0, pt0, ir1, ov1, pt1, ir2, ov2, pt2;
    logic [2:0]  op0, op1;
    logic [12:0] or0, or1;
    logic [0:0]  bi0, bi1;
    logic [5:0]  op2;
    logic [25:0] or2;
    logic [1:0]  bi2;

    instr_assembler #(.BUS_W(8), .BEATS(2), .OP_W(3), .ABORT_ON_GAP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready), .opcode(op0),
        .operand(or0), .beat_idx(bi0), .partial(pt0));

    instr_assembler #(.BUS_W(8), .BEATS(2), .OP_W(3), .ABORT_ON_GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready), .opcode(op1),
        .operand(or1), .beat_idx(bi1), .partial(pt1));

    instr_assembler #(.BUS_W(8), .BEATS(4), .OP_W(6), .ABORT_ON_GAP(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir2), .out_valid(ov2), .out_ready(out_ready), .opcode(op2),
        .operand(or2), .beat_idx(bi2), .partial(pt2));

    logic [63:0] g_ir [3];
    logic [63:0] g_ov [3];
    logic [63:0] g_op [3];
    logic [63:0] g_opd[3];
    logic [63:0] g_bi [3];
    logic [63:0] g_pt [3];

    assign g_ir[0] = 64'(ir0);  assign g_ir[1] = 64'(ir1);  assign g_ir[2] = 64'(ir2);
    assign g_ov[0] = 64'(ov0);  assign g_ov[1] = 64'(ov1);  assign g_ov[2] = 64'(ov2);
    assign g_op[0] = 64'(op0);  assign g_op[1] = 64'(op1);  assign g_op[2] = 64'(op2);
    assign g_opd[0] = 64'(or0); assign g_opd[1] = 64'(or1); assign g_opd[2] = 64'(or2);
    assign g_bi[0] = 64'(bi0);  assign g_bi[1] = 64'(bi1);  assign g_bi[2] = 64'(bi2);
    assign g_pt[0] = 64'(pt0);  assign g_pt[1] = 64'(pt1);  assign g_pt[2] = 64'(pt2);

    int cfg_beats[3];
    int cfg_opw  [3];
    bit cfg_abort[3];

    // Reference model: number of beats collected so far, the beats packed
    // MSB-first, the held instruction and whether it is still on offer.
    int          m_cnt  [3];
    logic [63:0] m_acc  [3];
    logic [63:0] m_out  [3];
    bit          m_valid[3];
    bit          m_rdy  [3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d]   = 0;
            m_acc[d]   = '0;
            m_out[d]   = '0;
            m_valid[d] = 1'b0;
            m_rdy[d]   = 1'b0;
        end
    endtask

    function automatic bit exp_ready(input int d);
        if (flush) return 1'b0;
        if (m_cnt[d] != cfg_beats[d] - 1) return 1'b1;
        return !m_valid[d] || out_ready;
    endfunction

    function automatic logic [63:0] exp_opcode(input int d);
        int iw = 8 * cfg_beats[d];
        return (m_out[d] >> (iw - cfg_opw[d])) & ((64'd1 << cfg_opw[d]) - 1);
    endfunction

    function automatic logic [63:0] exp_operand(input int d);
        int iw = 8 * cfg_beats[d];
        return m_out[d] & ((64'd1 << (iw - cfg_opw[d])) - 1);
    endfunction

    // One clock edge of the model, using the ready values seen before the edge.
    task automatic step_model();
        for (int d = 0; d < 3; d++) begin
            if (flush) begin
                m_cnt[d]   = 0;
                m_valid[d] = 1'b0;
            end else if (in_valid && m_rdy[d]) begin
                if (m_cnt[d] == 0) m_acc[d] = '0;
                m_acc[d] = (m_acc[d] << 8) | 64'(in_data);
                m_cnt[d]++;
                if (m_cnt[d] == cfg_beats[d]) begin
                    m_out[d]   = m_acc[d];
                    m_valid[d] = 1'b1;
                    m_cnt[d]   = 0;
                    $display("d%0d instruction %h", d, m_out[d]);
                end else if (m_valid[d] && out_ready) begin
                    m_valid[d] = 1'b0;
                end
            end else begin
                if (m_valid[d] && out_ready) m_valid[d] = 1'b0;
                if (cfg_abort[d] && m_cnt[d] != 0) m_cnt[d] = 0;
            end
        end
    endtask

    task automatic check_outs(input string ph);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_d%0d_out_valid", ph, d), g_ov[d], 64'(m_valid[d]));
            chk($sformatf("%s_d%0d_opcode", ph, d), g_op[d], exp_opcode(d));
            chk($sformatf("%s_d%0d_operand", ph, d), g_opd[d], exp_operand(d));
            chk($sformatf("%s_d%0d_beat_idx", ph, d), g_bi[d], 64'(m_cnt[d]));
            chk($sformatf("%s_d%0d_partial", ph, d), g_pt[d], 64'(m_cnt[d] != 0));
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d_in, input bit ordy, input bit fl,
                       input string ph);
        @(negedge clk);
        in_valid  = v;
        in_data   = d_in;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int d = 0; d < 3; d++) begin
            m_rdy[d] = exp_ready(d);
            chk($sformatf("%s_d%0d_in_ready", ph, d), g_ir[d], 64'(m_rdy[d]));
        end
        @(posedge clk);
        step_model();
        #1;
        check_outs(ph);
    endtask

    initial begin
        cfg_beats = '{2, 2, 4};
        cfg_opw   = '{3, 3, 6};
        cfg_abort = '{1'b1, 1'b0, 1'b0};
        reset_model();

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #12;
        check_outs("reset");
        for (int d = 0; d < 3; d++) chk($sformatf("reset_d%0d_in_ready", d), g_ir[d], 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-beat fetch with a free consumer
        cyc(1, 8'hA5, 1, 0, "tp1a");
        cyc(1, 8'h3C, 1, 0, "tp1b");
        chk("tp1_out_valid", g_ov[0], 64'd1);
        chk("tp1_opcode", g_op[0], 64'h5);
        chk("tp1_operand", g_opd[0], 64'h053C);

        // Overlapped fetch behind a stalled output; the final beat waits
        cyc(1, 8'h12, 0, 0, "tp2a");
        cyc(1, 8'h34, 0, 0, "tp2b");
        chk("tp2_final_held", g_ir[1], 64'd0);
        cyc(1, 8'h34, 1, 0, "tp2c");
        chk("tp2_opcode", g_op[1], 64'h0);
        chk("tp2_operand", g_opd[1], 64'h1234);
        chk("tp2_out_valid", g_ov[1], 64'd1);

        // Gap handling: abort vs hold
        cyc(0, 8'h00, 1, 1, "tp3f");
        cyc(1, 8'hFF, 1, 0, "tp3a");
        cyc(0, 8'h00, 1, 0, "tp3b");
        cyc(1, 8'h11, 1, 0, "tp3c");
        cyc(1, 8'h22, 1, 0, "tp3d");
        chk("tp3_abort_operand", g_opd[0], 64'h1122);
        chk("tp3_abort_opcode", g_op[0], 64'h0);
        chk("tp3_hold_operand", g_opd[1], 64'h1F11);
        chk("tp3_hold_opcode", g_op[1], 64'h7);
        chk("tp3_hold_partial", g_pt[1], 64'd1);

        // Four-beat instruction
        cyc(0, 8'h00, 1, 1, "tp4f");
        cyc(1, 8'hDE, 1, 0, "tp4a");
        cyc(1, 8'hAD, 1, 0, "tp4b");
        cyc(1, 8'hBE, 1, 0, "tp4c");
        cyc(1, 8'hEF, 1, 0, "tp4d");
        chk("tp4_opcode", g_op[2], 64'h37);
        chk("tp4_operand", g_opd[2], 64'h2ADBEEF);

        // Flush while holding an instruction and a partial fetch
        cyc(1, 8'h77, 0, 0, "tp5a");
        cyc(1, 8'h88, 0, 1, "tp5f");
        chk("tp5_out_valid", g_ov[0], 64'd0);
        chk("tp5_beat_idx", g_bi[0], 64'd0);
        cyc(1, 8'h12, 1, 0, "tp5b");
        cyc(1, 8'h34, 1, 0, "tp5c");
        chk("tp5_operand", g_opd[0], 64'h1234);
        chk("tp5_out_valid_after", g_ov[0], 64'd1);

        // Asynchronous reset between edges, mid-fetch
        cyc(1, 8'h55, 0, 0, "tp6a");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_outs("arst");
        for (int d = 0; d < 3; d++) chk($sformatf("arst_d%0d_in_ready", d), g_ir[d], 64'd1);
        #2;
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("arst_rel_d%0d_in_ready", d), g_ir[d], 64'd1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 3, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
